// File: rtl/layer_sequencer.sv
// Layer sequencer: walks each layer through a held reset and a run phase, aborts on
// a per-layer timeout, then scans the final FC layer outputs for the argmax digit.
module layer_sequencer #(
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RST_HOLD       = 2
) (
    input  logic                     clk,
    input  logic                     iRst_n,
    input  logic                     start,
    input  logic [NUM_LAYERS-1:0]    layer_done,
    input  logic [NUM_LAYERS-1:0]    layer_overflow,
    input  logic [NUM_LAYERS*11-1:0] layer_rom_addr,
    input  logic [79:0]              fc_out,
    output logic [NUM_LAYERS-1:0]    layer_ena,
    output logic [NUM_LAYERS-1:0]    layer_rst_n,
    output logic [10:0]              rom_addr,
    output logic                     busy,
    output logic                     result_valid,
    output logic [3:0]               result_digit,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CMAX = (TIMEOUT_CYCLES > RST_HOLD) ? TIMEOUT_CYCLES : RST_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_RST_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] C_TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST     = LW'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LRST   = 3'd1,
        S_LRUN   = 3'd2,
        S_LNEXT  = 3'd3,
        S_ARGMAX = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t                r_state;
    logic [LW-1:0]         r_l;
    logic [CW-1:0]         r_c;
    logic [3:0]            r_k;
    logic [6:0]            r_best_val;
    logic [3:0]            r_best_idx;
    logic                  r_overflow;
    logic [3:0]            r_result_digit;
    logic [NUM_LAYERS-1:0] r_layer_ena;
    logic [NUM_LAYERS-1:0] r_layer_rst_n;
    logic                  r_busy;
    logic                  r_result_valid;
    logic                  r_timeout_err;

    state_t                w_state_nxt;
    logic [LW-1:0]         w_l_nxt;
    logic [CW-1:0]         w_c_nxt;
    logic [3:0]            w_k_nxt;
    logic [6:0]            w_best_val_nxt;
    logic [3:0]            w_best_idx_nxt;
    logic                  w_overflow_nxt;
    logic [3:0]            w_digit_nxt;
    logic                  w_done_l;
    logic                  w_ovf_l;
    logic [10:0]           w_rom_sel;
    logic [7:0]            w_entry;
    logic [6:0]            w_cand;
    logic [NUM_LAYERS-1:0] w_sel_nxt;
    logic [NUM_LAYERS-1:0] w_ena_nxt;
    logic [NUM_LAYERS-1:0] w_rst_n_nxt;
    logic                  w_busy_nxt;
    logic                  w_valid_nxt;
    logic                  w_timeout_nxt;

    // Select the active layer's inputs and the current fc_out entry with masked ORs.
    always_comb begin
        w_done_l  = 1'b0;
        w_ovf_l   = 1'b0;
        w_rom_sel = 11'd0;
        w_entry   = 8'd0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_done_l  = w_done_l  | (layer_done[i]     & (r_l == LW'(i)));
            w_ovf_l   = w_ovf_l   | (layer_overflow[i] & (r_l == LW'(i)));
            w_rom_sel = w_rom_sel | (layer_rom_addr[11*i +: 11] & {11{r_l == LW'(i)}});
        end
        for (int i = 0; i < 10; i++) begin
            w_entry = w_entry | (fc_out[8*i +: 8] & {8{r_k == 4'(i)}});
        end
        // Negative entries can never win, so they compete as magnitude zero.
        w_cand   = w_entry[7] ? 7'd0 : w_entry[6:0];
        rom_addr = ((r_state == S_LRST) || (r_state == S_LRUN)) ? w_rom_sel : 11'd0;
    end

    // Next-state logic for the sequencer and the argmax scan.
    always_comb begin
        w_state_nxt    = r_state;
        w_l_nxt        = r_l;
        w_c_nxt        = r_c;
        w_k_nxt        = r_k;
        w_best_val_nxt = r_best_val;
        w_best_idx_nxt = r_best_idx;
        w_overflow_nxt = r_overflow;
        w_digit_nxt    = r_result_digit;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_nxt    = S_LRST;
                    w_l_nxt        = {LW{1'b0}};
                    w_c_nxt        = {CW{1'b0}};
                    w_overflow_nxt = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_LRST: begin
                if (r_c == C_RST_LAST) begin
                    w_state_nxt = S_LRUN;
                    w_c_nxt     = {CW{1'b0}};
                end else begin
                    w_c_nxt = r_c + CW'(1);
                end
            end
            S_LRUN: begin
                // Done is checked first so it wins over a coincident timeout.
                if (w_done_l) begin
                    w_overflow_nxt = r_overflow | w_ovf_l;
                    w_state_nxt    = S_LNEXT;
                    w_c_nxt        = {CW{1'b0}};
                end else if (r_c == C_TO_LAST) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_c_nxt = r_c + CW'(1);
                end
            end
            S_LNEXT: begin
                if (r_l == L_LAST) begin
                    w_state_nxt    = S_ARGMAX;
                    w_k_nxt        = 4'd0;
                    w_best_val_nxt = 7'd0;
                    w_best_idx_nxt = 4'd0;
                end else begin
                    w_state_nxt = S_LRST;
                    w_l_nxt     = r_l + LW'(1);
                    w_c_nxt     = {CW{1'b0}};
                end
            end
            S_ARGMAX: begin
                if (w_cand > r_best_val) begin
                    w_best_val_nxt = w_cand;
                    w_best_idx_nxt = r_k;
                end else begin
                    w_best_val_nxt = r_best_val;
                end
                if (r_k == 4'd9) begin
                    w_state_nxt = S_DONE;
                    w_k_nxt     = 4'd0;
                    w_digit_nxt = w_best_idx_nxt;
                end else begin
                    w_k_nxt = r_k + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values decoded from the next state so the outputs can be registered.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_sel_nxt[i] = (w_l_nxt == LW'(i));
        end
        w_ena_nxt     = {NUM_LAYERS{1'b0}};
        w_rst_n_nxt   = {NUM_LAYERS{1'b1}};
        w_busy_nxt    = 1'b0;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (w_state_nxt)
            S_LRST: begin
                w_ena_nxt   = w_sel_nxt;
                w_rst_n_nxt = ~w_sel_nxt;
                w_busy_nxt  = 1'b1;
            end
            S_LRUN: begin
                w_ena_nxt  = w_sel_nxt;
                w_busy_nxt = 1'b1;
            end
            S_LNEXT, S_ARGMAX: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_valid_nxt = 1'b1;
            end
            S_ERROR: begin
                w_rst_n_nxt   = {NUM_LAYERS{1'b0}};
                w_timeout_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; layers are held in reset while iRst_n is low.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            r_state        <= S_IDLE;
            r_l            <= {LW{1'b0}};
            r_c            <= {CW{1'b0}};
            r_k            <= 4'd0;
            r_best_val     <= 7'd0;
            r_best_idx     <= 4'd0;
            r_overflow     <= 1'b0;
            r_result_digit <= 4'd0;
            r_layer_ena    <= {NUM_LAYERS{1'b0}};
            r_layer_rst_n  <= {NUM_LAYERS{1'b0}};
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_l            <= w_l_nxt;
            r_c            <= w_c_nxt;
            r_k            <= w_k_nxt;
            r_best_val     <= w_best_val_nxt;
            r_best_idx     <= w_best_idx_nxt;
            r_overflow     <= w_overflow_nxt;
            r_result_digit <= w_digit_nxt;
            r_layer_ena    <= w_ena_nxt;
            r_layer_rst_n  <= w_rst_n_nxt;
            r_busy         <= w_busy_nxt;
            r_result_valid <= w_valid_nxt;
            r_timeout_err  <= w_timeout_nxt;
        end
    end

    assign layer_ena    = r_layer_ena;
    assign layer_rst_n  = r_layer_rst_n;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result_digit = r_result_digit;
    assign overflow     = r_overflow;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: behavioural layer models, a scoreboard of
// expected results per inference, and immediate-assertion comparisons.
module tb_layer_sequencer;

    localparam int NL = 3;
    localparam int TO = 20;
    localparam int RH = 2;

    logic           clk = 1'b0;
    logic           iRst_n;
    logic           start;
    logic [NL-1:0]  layer_done;
    logic [NL-1:0]  layer_overflow;
    logic [NL*11-1:0] layer_rom_addr;
    logic [79:0]    fc_out;
    logic [NL-1:0]  layer_ena;
    logic [NL-1:0]  layer_rst_n;
    logic [10:0]    rom_addr;
    logic           busy;
    logic           result_valid;
    logic [3:0]     result_digit;
    logic           overflow;
    logic           timeout_err;

    layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .RST_HOLD(RH)) dut (
        .clk(clk), .iRst_n(iRst_n), .start(start),
        .layer_done(layer_done), .layer_overflow(layer_overflow),
        .layer_rom_addr(layer_rom_addr), .fc_out(fc_out),
        .layer_ena(layer_ena), .layer_rst_n(layer_rst_n), .rom_addr(rom_addr),
        .busy(busy), .result_valid(result_valid), .result_digit(result_digit),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Layer models: count enabled cycles out of reset, raise done on the run_len-th one.
    int            run_len [NL];
    logic [NL-1:0] hang;
    int            cnt [NL];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!layer_rst_n[i]) cnt[i] <= 0;
            else if (layer_ena[i]) cnt[i] <= cnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            layer_done[i] = layer_ena[i] & layer_rst_n[i] & ~hang[i] & (cnt[i] >= run_len[i] - 1);
        end
    end

    typedef struct {
        logic [3:0] digit;
        logic       ovf;
        logic       to;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_rv"},    {31'd0, result_valid}, 32'd0);
        chk({tag, "_digit"}, {28'd0, result_digit}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
        chk({tag, "_to"},    {31'd0, timeout_err}, 32'd0);
        chk({tag, "_ena"},   {29'd0, layer_ena}, 32'd0);
        chk({tag, "_rstn"},  {29'd0, layer_rst_n}, 32'd0);
        chk({tag, "_rom"},   {21'd0, rom_addr}, 32'd0);
    endtask

    // Edges from the start-sampling edge to the DONE/ERROR edge, counting that edge as 1.
    function automatic int exp_latency();
        int  lat;
        logic stop;
        lat  = 1;
        stop = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (!stop) begin
                if (hang[i]) begin
                    lat  = lat + RH + TO;
                    stop = 1'b1;
                end else begin
                    lat = lat + RH + run_len[i] + 1;
                end
            end
        end
        if (!stop) lat = lat + 10;
        return lat;
    endfunction

    task automatic do_run(input string tag, input logic [79:0] fc, input logic [3:0] exp_digit,
                          input logic exp_ovf, input logic exp_to, input int poke1, input int poke2);
        exp_t        e;
        int          edges;
        int          viol;
        logic [10:0] exp_rom;
        fc_out = fc;
        sb.push_back('{exp_digit, exp_ovf, exp_to, exp_latency()});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        viol  = 0;
        chk({tag, "_busy_on"},    {31'd0, busy}, 32'd1);
        chk({tag, "_ovf_clr"},    {31'd0, overflow}, 32'd0);
        chk({tag, "_rv_clr"},     {31'd0, result_valid}, 32'd0);
        chk({tag, "_first_ena"},  {29'd0, layer_ena}, 32'd1);
        chk({tag, "_first_rstn"}, {29'd0, layer_rst_n}, 32'd6);
        while (!(result_valid || timeout_err) && edges < 500) begin
            exp_rom = 11'd0;
            for (int i = 0; i < NL; i++) begin
                if (layer_ena[i]) exp_rom = layer_rom_addr[11*i +: 11];
            end
            if (!$onehot0(layer_ena)) viol++;
            if ((layer_rst_n | layer_ena) !== {NL{1'b1}}) viol++;
            if (rom_addr !== exp_rom) viol++;
            if (busy !== 1'b1) viol++;
            start = (edges == poke1) || (edges == poke2);
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, "_invariants"}, viol, 32'd0);
        chk({tag, "_latency"},    edges, e.lat);
        chk({tag, "_to"},         {31'd0, timeout_err}, {31'd0, e.to});
        chk({tag, "_busy_off"},   {31'd0, busy}, 32'd0);
        chk({tag, "_ena_off"},    {29'd0, layer_ena}, 32'd0);
        chk({tag, "_rstn_end"},   {29'd0, layer_rst_n}, e.to ? 32'd0 : 32'd7);
        if (!e.to) chk({tag, "_digit"}, {28'd0, result_digit}, {28'd0, e.digit});
        repeat (3) @(negedge clk);
        chk({tag, "_rv_hold"},  {31'd0, result_valid}, {31'd0, ~e.to});
        chk({tag, "_ovf_hold"}, {31'd0, overflow}, {31'd0, e.ovf});
    endtask

    logic [79:0] fc_a;
    logic [79:0] fcv;

    initial begin
        iRst_n         = 1'b0;
        start          = 1'b0;
        hang           = '0;
        layer_overflow = '0;
        run_len        = '{5, 7, 3};
        layer_rom_addr = {11'h3C3, 11'h2A5, 11'h155};
        fc_a           = {10{8'h10}};
        fc_a[48 +: 8]  = 8'h40;
        fc_out         = fc_a;

        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        iRst_n = 1'b1;
        @(negedge clk);
        chk("rel_rstn", {29'd0, layer_rst_n}, 32'd7);
        chk("rel_busy", {31'd0, busy}, 32'd0);

        do_run("basic", fc_a, 4'd6, 1'b0, 1'b0, 0, 0);

        fcv = '0; fcv[16 +: 8] = 8'h7F; fcv[64 +: 8] = 8'h7F;
        do_run("tie", fcv, 4'd2, 1'b0, 1'b0, 0, 0);

        fcv = '0; fcv[0 +: 8] = 8'hFF;
        do_run("neg0", fcv, 4'd0, 1'b0, 1'b0, 0, 0);

        fcv = '0; fcv[24 +: 8] = 8'h85; fcv[40 +: 8] = 8'h05;
        do_run("sign", fcv, 4'd5, 1'b0, 1'b0, 0, 0);

        fcv = {10{8'h7E}}; fcv[72 +: 8] = 8'h7F;
        do_run("last", fcv, 4'd9, 1'b0, 1'b0, 0, 0);

        layer_overflow = 3'b001;
        do_run("ovf", fc_a, 4'd6, 1'b1, 1'b0, 0, 0);
        layer_overflow = 3'b000;

        do_run("busy_start", fc_a, 4'd6, 1'b0, 1'b0, 10, 28);

        hang = 3'b010;
        fcv = '0; fcv[16 +: 8] = 8'h7F; fcv[64 +: 8] = 8'h7F;
        do_run("timeout", fcv, 4'd0, 1'b0, 1'b1, 0, 0);
        hang = 3'b000;

        do_run("recover", fcv, 4'd2, 1'b0, 1'b0, 0, 0);

        // Reset in the middle of layer 1's run phase.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_ena", {29'd0, layer_ena}, 32'd2);
        chk("mid_rom", {21'd0, rom_addr}, 32'h2A5);
        iRst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        iRst_n = 1'b1;
        @(negedge clk);
        chk("midrel_rstn", {29'd0, layer_rst_n}, 32'd7);
        do_run("after_rst", fc_a, 4'd6, 1'b0, 1'b0, 0, 0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
